// File: rtl/stream_receiver_if.sv
// Ready/valid word interface between stream_receiver and its sink.
// master: the receiver driving words out; slave: the consuming sink.
interface stream_receiver_if #(
    parameter int DATA_W = 16
);
    logic              out_ready;
    logic              out_valid;
    logic [1:0]        out_channel;
    logic [DATA_W-1:0] out_data;

    modport master (
        input  out_ready,
        output out_valid,
        output out_channel,
        output out_data
    );

    modport slave (
        output out_ready,
        input  out_valid,
        input  out_channel,
        input  out_data
    );
endinterface

// File: rtl/stream_receiver.sv
// stream_receiver: deframes a 2-bit serial symbol stream into DATA_W-bit
// words tagged with a channel (0..2), validates each frame against its XOR
// check symbol, and queues good words in a DEPTH-entry FIFO toward a
// ready/valid sink.
// Frame: START(11), CHAN, DATA_W/2 data symbols (MSB pair first), CHECK.
// Optional per-channel statistics are compiled in with the macro
// STREAM_RECEIVER_STATS_EN.
module stream_receiver #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     arst,
    input  logic [1:0]               rx_data,
    stream_receiver_if.master        sink,
    output logic                     frame_err,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   level
`ifdef STREAM_RECEIVER_STATS_EN
    ,
    output logic [15:0]              good_cnt0,
    output logic [15:0]              good_cnt1,
    output logic [15:0]              good_cnt2,
    output logic [15:0]              err_cnt
`endif
);

    localparam int NSYM = DATA_W / 2;
    localparam int CW   = (NSYM > 1) ? $clog2(NSYM) : 1;
    localparam int PW   = $clog2(DEPTH);
    localparam int LW   = PW + 1;
    localparam int WW   = DATA_W + 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHAN,
        S_DATA,
        S_CHECK
    } state_t;

    state_t            state;
    logic [1:0]        chan_q;
    logic [1:0]        xor_q;
    logic [DATA_W-1:0] shift_q;
    logic [CW-1:0]     sym_cnt;

    logic [WW-1:0]     mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [WW-1:0]     head;

    logic frame_good;
    logic full;
    logic pop;
    logic push;
    logic drop;

    // Frame verdict and FIFO write/pop decisions for the current edge
    always_comb begin
        frame_good = (state == S_CHECK) && (chan_q != 2'b11) && (rx_data == xor_q);
        full       = (level == LW'(DEPTH));
        pop        = sink.out_valid && sink.out_ready;
        push       = frame_good && (!full || pop);
        drop       = frame_good && full && !pop;
    end

    // Deframing FSM: tracks frame position, accumulates payload and XOR
    always_ff @(posedge clk) begin
        if (arst) begin
            state     <= S_IDLE;
            chan_q    <= '0;
            xor_q     <= '0;
            shift_q   <= '0;
            sym_cnt   <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    xor_q   <= '0;
                    sym_cnt <= '0;
                    if (rx_data == 2'b11) begin
                        state <= S_CHAN;
                    end
                end
                S_CHAN: begin
                    chan_q <= rx_data;
                    state  <= S_DATA;
                end
                S_DATA: begin
                    shift_q <= (shift_q << 2) | DATA_W'(rx_data);
                    xor_q   <= xor_q ^ rx_data;
                    if (sym_cnt == CW'(NSYM - 1)) begin
                        sym_cnt <= '0;
                        state   <= S_CHECK;
                    end else begin
                        sym_cnt <= sym_cnt + CW'(1);
                    end
                end
                S_CHECK: begin
                    frame_err <= !((chan_q != 2'b11) && (rx_data == xor_q));
                    xor_q     <= '0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Output FIFO: storage, pointers, occupancy and overflow pulse.
    // At full with a pop, wr_ptr equals rd_ptr; the slot being popped is
    // the one being refilled, so both happen on the same edge.
    always_ff @(posedge clk) begin
        if (arst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= drop;
            if (push) begin
                mem[wr_ptr] <= {chan_q, shift_q};
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Head word presented to the sink directly from storage
    always_comb begin
        head             = mem[rd_ptr];
        sink.out_valid   = (level != '0);
        sink.out_channel = head[WW-1:DATA_W];
        sink.out_data    = head[DATA_W-1:0];
    end

`ifdef STREAM_RECEIVER_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Saturating per-channel good-frame and bad-frame counters
    always_ff @(posedge clk) begin
        if (arst) begin
            good_cnt0 <= '0;
            good_cnt1 <= '0;
            good_cnt2 <= '0;
            err_cnt   <= '0;
        end else begin
            if (frame_good) begin
                case (chan_q)
                    2'd0:    good_cnt0 <= sat_inc(good_cnt0);
                    2'd1:    good_cnt1 <= sat_inc(good_cnt1);
                    2'd2:    good_cnt2 <= sat_inc(good_cnt2);
                    default: ;
                endcase
            end
            if ((state == S_CHECK) && !frame_good) begin
                err_cnt <= sat_inc(err_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_stream_receiver.sv
// Directed bench for stream_receiver with a frame-level reference model
// compared against the DUT on every cycle, plus literal expectations.
module tb_stream_receiver;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 16;
    localparam int NSYM   = DATA_W / 2;

    logic       clk = 1'b0;
    logic       arst;
    logic [1:0] rx_data;
    logic       frame_err;
    logic       overflow;
    logic [2:0] level;

    stream_receiver_if #(.DATA_W(DATA_W)) sink_if ();

    stream_receiver #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) dut (
        .clk       (clk),
        .arst      (arst),
        .rx_data   (rx_data),
        .sink      (sink_if),
        .frame_err (frame_err),
        .overflow  (overflow),
        .level     (level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ferr_n = 0;
    int ovf_n  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: collects whole frames and judges them by the frame rules
    logic [17:0] mq[$];
    bit          m_ferr;
    bit          m_ovf;
    bit          in_frame;
    int          pos;
    logic [1:0]  syms[NSYM+2];

    always @(posedge clk) begin : model
        bit          m_pop;
        bit          m_wr;
        logic [1:0]  x;
        logic [15:0] d;
        if (arst) begin
            mq.delete();
            in_frame = 0;
            pos      = 0;
            m_ferr   = 0;
            m_ovf    = 0;
        end else begin
            m_pop  = (mq.size() != 0) && sink_if.out_ready;
            m_wr   = 0;
            m_ferr = 0;
            m_ovf  = 0;
            if (!in_frame) begin
                if (rx_data == 2'b11) begin
                    in_frame = 1;
                    pos      = 0;
                end
            end else begin
                syms[pos] = rx_data;
                pos++;
                if (pos == NSYM + 2) begin
                    in_frame = 0;
                    d = '0;
                    x = '0;
                    for (int i = 1; i <= NSYM; i++) begin
                        d = {d[13:0], syms[i]};
                        x = x ^ syms[i];
                    end
                    if (syms[0] == 2'b11 || syms[NSYM+1] != x) m_ferr = 1;
                    else if (mq.size() == DEPTH && !m_pop)    m_ovf  = 1;
                    else                                       m_wr   = 1;
                end
            end
            if (m_pop) void'(mq.pop_front());
            if (m_wr)  mq.push_back({syms[0], d});
        end
        #1;
        check("out_valid", 32'(sink_if.out_valid), 32'(mq.size() != 0));
        check("level", 32'(level), 32'(mq.size()));
        check("frame_err", 32'(frame_err), 32'(m_ferr));
        check("overflow", 32'(overflow), 32'(m_ovf));
        if (mq.size() != 0) begin
            check("out_channel", 32'(sink_if.out_channel), 32'(mq[0][17:16]));
            check("out_data", 32'(sink_if.out_data), 32'(mq[0][15:0]));
        end
    end

    // Pulse counters for one-shot expectations
    always @(posedge clk) begin
        #1;
        if (frame_err) ferr_n++;
        if (overflow)  ovf_n++;
    end

    task automatic send_sym(input logic [1:0] s);
        @(negedge clk);
        rx_data = s;
    endtask

    task automatic idle();
        @(negedge clk);
        rx_data = 2'b00;
    endtask

    task automatic send_frame(input logic [1:0] ch, input logic [15:0] data,
                              input bit bad, input bit ready_on_check);
        logic [1:0] x;
        x = '0;
        send_sym(2'b11);
        send_sym(ch);
        for (int i = 0; i < NSYM; i++) begin
            send_sym(data[15-2*i -: 2]);
            x = x ^ data[15-2*i -: 2];
        end
        @(negedge clk);
        rx_data = x ^ {1'b0, bad};
        if (ready_on_check) sink_if.out_ready = 1'b1;
    endtask

    logic [1:0] ch_tab[4];
    int f0;
    int o0;

    initial begin
        arst              = 1'b1;
        rx_data           = 2'b11;
        sink_if.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        arst    = 1'b0;
        rx_data = 2'b00;

        // Reset state
        check("rst_valid", 32'(sink_if.out_valid), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_data", 32'(sink_if.out_data), 32'd0);
        check("rst_chan", 32'(sink_if.out_channel), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);

        // Good frame: chan 1, 16'hA5C3, check 00
        sink_if.out_ready = 1'b1;
        repeat (3) send_sym(2'b00);
        send_frame(2'd1, 16'hA5C3, 0, 0);
        idle();
        check("good_valid", 32'(sink_if.out_valid), 32'd1);
        check("good_chan", 32'(sink_if.out_channel), 32'd1);
        check("good_data", 32'(sink_if.out_data), 32'hA5C3);
        idle();
        check("good_level_after", 32'(level), 32'd0);

        // Bad check symbol
        f0 = ferr_n;
        send_frame(2'd1, 16'hA5C3, 1, 0);
        idle();
        check("badchk_ferr", 32'(frame_err), 32'd1);
        check("badchk_valid", 32'(sink_if.out_valid), 32'd0);
        idle();
        check("badchk_pulses", 32'(ferr_n - f0), 32'd1);
        check("badchk_level", 32'(level), 32'd0);

        // Invalid channel with correct check
        send_frame(2'd3, 16'h1234, 0, 0);
        idle();
        check("badch_ferr", 32'(frame_err), 32'd1);
        check("badch_level", 32'(level), 32'd0);

        // Backpressure and overflow
        sink_if.out_ready = 1'b0;
        o0 = ovf_n;
        ch_tab = '{2'd0, 2'd1, 2'd2, 2'd0};
        send_frame(2'd0, 16'h0001, 0, 0);
        send_frame(2'd1, 16'h0002, 0, 0);
        send_frame(2'd2, 16'h0003, 0, 0);
        send_frame(2'd0, 16'h0004, 0, 0);
        send_frame(2'd1, 16'h0005, 0, 0);
        idle();
        idle();
        check("ovf_level", 32'(level), 32'd4);
        check("ovf_pulses", 32'(ovf_n - o0), 32'd1);
        sink_if.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("ovf_drain_data", 32'(sink_if.out_data), 32'(i + 1));
            check("ovf_drain_chan", 32'(sink_if.out_channel), 32'(ch_tab[i]));
            @(negedge clk);
        end
        check("ovf_drained", 32'(level), 32'd0);

        // Reset mid-frame, then a full good frame
        f0 = ferr_n;
        send_sym(2'b11);
        send_sym(2'd0);
        repeat (4) send_sym(2'b01);
        @(negedge clk);
        arst    = 1'b1;
        rx_data = 2'b11;
        @(negedge clk);
        arst    = 1'b0;
        rx_data = 2'b00;
        send_frame(2'd2, 16'hFFFF, 0, 0);
        idle();
        check("rstmid_valid", 32'(sink_if.out_valid), 32'd1);
        check("rstmid_chan", 32'(sink_if.out_channel), 32'd2);
        check("rstmid_data", 32'(sink_if.out_data), 32'hFFFF);
        idle();
        check("rstmid_no_ferr", 32'(ferr_n - f0), 32'd0);

        // Simultaneous write and pop at full
        sink_if.out_ready = 1'b0;
        send_frame(2'd0, 16'h0010, 0, 0);
        send_frame(2'd1, 16'h0011, 0, 0);
        send_frame(2'd2, 16'h0012, 0, 0);
        send_frame(2'd0, 16'h0013, 0, 0);
        idle();
        check("simul_full", 32'(level), 32'd4);
        o0 = ovf_n;
        send_frame(2'd1, 16'h0014, 0, 1);
        @(negedge clk);
        rx_data           = 2'b00;
        sink_if.out_ready = 1'b0;
        check("simul_level", 32'(level), 32'd4);
        check("simul_no_ovf", 32'(ovf_n - o0), 32'd0);
        ch_tab = '{2'd1, 2'd2, 2'd0, 2'd1};
        sink_if.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("simul_drain_data", 32'(sink_if.out_data), 32'(16'h0011 + i));
            check("simul_drain_chan", 32'(sink_if.out_channel), 32'(ch_tab[i]));
            @(negedge clk);
        end
        check("simul_drained", 32'(level), 32'd0);

        repeat (3) idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_receiver.md
Name: stream_receiver

Overview:
- Downstream consumer of the transmitter's 2-bit serial output.
- Deframes the symbol stream into 16-bit words tagged with a source channel (0..2).
- Checks each frame and buffers good words in a small FIFO toward a ready/valid sink.
- Single clock domain, clocked by the transmitter's read_clk.

Parameters:
- DEPTH, 4, output FIFO depth in words; power of two, 2..16.
- DATA_W, 16, payload width; must be even (DATA_W/2 symbols per frame).

Ports:
- clk  in  1  clock (same as transmitter read_clk); all logic on rising edge.
- arst  in  1  synchronous active-high reset; sampled on clk rising edge only.
- rx_data  in  2  serial symbol stream from the transmitter output_data.
- out_ready  in  1  sink accepts the head word when high.
- out_valid  out  1  head word present.
- out_channel  out  2  channel tag of head word.
- out_data  out  DATA_W  payload of head word.
- frame_err  out  1  one-cycle pulse on a bad frame.
- overflow  out  1  one-cycle pulse when a good frame is dropped because the FIFO is full.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Frame format, one symbol per clk:
  - START = 2'b11.
  - CHAN symbol: 0..2 valid, 3 invalid.
  - DATA_W/2 data symbols, MSB pair first.
  - CHECK symbol = XOR of all data symbols.
  - Idle symbols are 2'b00; any non-11 symbol in IDLE is ignored.
- FSM states and transitions:
  - IDLE -> CHAN when rx_data==11.
  - CHAN -> DATA; latch channel.
  - DATA: shift rx_data into a shift register; a symbol counter runs 0..DATA_W/2-1; go to CHECK after the last data symbol.
  - CHECK -> IDLE unconditionally.
- No resynchronisation inside a frame: 2'b11 in CHAN/DATA/CHECK is treated as ordinary content.
- Frame validity: good iff channel != 3 and CHECK == running XOR.
- Bad frame: frame_err pulses high in the cycle after the CHECK symbol is sampled; nothing is written to the FIFO.
- Good frame: {channel, data} is written to the FIFO on the edge that samples CHECK.
  - If the FIFO was empty, out_valid is high in the next cycle (latency: CHECK symbol presented at cycle N, out_valid at N+1).
- Good frame with FIFO full and no pop on the same edge: word dropped; overflow pulses the next cycle; FIFO contents unchanged.
- Full FIFO with a pop (out_valid && out_ready) on the same edge as the write: both happen; level unchanged; no overflow.
- Pop: on an edge with out_valid && out_ready, the head advances.
- Head-word stability: out_channel and out_data hold while out_valid && !out_ready.
- Empty FIFO: out_valid=0; out_channel and out_data are don't-care but must not be X after reset.
- Pointers: wrap modulo DEPTH; level = writes - pops, range 0..DEPTH.
- Reset:
  - FSM -> IDLE; counter, XOR and shift register cleared.
  - FIFO emptied: out_valid=0, level=0, out_data=0, out_channel=0, frame_err=0, overflow=0.
  - A frame in progress at reset is discarded with no frame_err.
  - rx_data is ignored during the arst cycle.
- Back-to-back frames: START may follow CHECK immediately, giving a minimum frame period of DATA_W/2+3 cycles.

Optional Feature:
- Macro: STREAM_RECEIVER_STATS_EN.
- Defined:
  - Adds outputs good_cnt0, good_cnt1, good_cnt2 (16 bits each) and err_cnt (16 bits).
  - good_cntN increments on each good frame for channel N, including frames dropped by overflow.
  - err_cnt increments with each frame_err pulse.
  - All counters saturate at 16'hFFFF and clear on arst.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Good frame:
  - Stimulus: arst, idle 00 x3, then 11, 01, 10,10,01,01,11,00,00,11, check 00 (chan 1, data 16'hA5C3), out_ready=1.
  - Response: out_valid=1 one cycle after the check symbol with out_channel=1, out_data=16'hA5C3; level returns 0.
- Bad check:
  - Stimulus: same frame with check 01.
  - Response: frame_err pulses once; out_valid stays 0; level stays 0.
- Invalid channel:
  - Stimulus: CHAN=11 with correct check.
  - Response: frame_err pulse; no write.
- Backpressure and overflow:
  - Stimulus: out_ready=0; send 5 good frames on channels 0,1,2,0,1 with data 16'h0001..16'h0005 (DEPTH=4).
  - Response: level=4; overflow pulses once on the 5th frame; then out_ready=1 pops 0001..0004 in order with channels 0,1,2,0.
- Reset mid-frame:
  - Stimulus: arst asserted after the 4th data symbol, then a full good frame (chan 2, 16'hFFFF, check 00).
  - Response: no frame_err for the aborted frame; the second frame is delivered intact.
- Simultaneous write and pop at full:
  - Stimulus: fill to 4; out_ready=1 exactly on the edge that samples a new good frame's CHECK.
  - Response: level stays 4, no overflow, order preserved.
